// File: rtl/regfile_pkg.sv
// Register-file constants and port widths shared with Regfile, plus the dump engine's
// FSM encoding.
package regfile_pkg;
   localparam int REG_DATA_W = 16;
   localparam int REG_ADDR_W = 3;
   localparam int REG_NUM    = 8;

   typedef logic [REG_DATA_W-1:0] reg_data_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_SEND0,
      S_SEND1,
      S_CHK,
      S_DONE
   } dump_state_e;
endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready word stream from the dump engine (master) to a trace or debug consumer
// (slave).
interface regfile_dump_if #(
   parameter int DATA_W = regfile_pkg::REG_DATA_W,
   parameter int ADDR_W = regfile_pkg::REG_ADDR_W
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_index;
   logic              out_last;
   logic              out_chk;

   modport master (output out_valid, out_data, out_index, out_last, out_chk,
                   input  out_ready);
   modport slave  (input  out_valid, out_data, out_index, out_last, out_chk,
                   output out_ready);
endinterface

// File: rtl/regdump_pair_buf.sv
// Two-entry capture buffer holding one coherent register pair, with the word-select
// mux that drives the stream data.
module regdump_pair_buf #(
   parameter int DATA_W = regfile_pkg::REG_DATA_W
) (
   input  logic              clock,
   input  logic              load,
   input  logic [DATA_W-1:0] d0,
   input  logic [DATA_W-1:0] d1,
   input  logic              sel,
   input  logic              oe,
   output logic [DATA_W-1:0] q
);
   logic [DATA_W-1:0] pair_q [2];

   // NOTE: no reset on the pair storage; it is always loaded before it is shown, and
   // the output is forced to zero whenever oe is low.
   always_ff @(posedge clock) begin
      if (load) begin
         pair_q[0] <= d0;
         pair_q[1] <= d1;
      end
   end

   assign q = oe ? pair_q[sel] : '0;
endmodule

// File: rtl/regfile_dump.sv
// Register-file dump engine: reads two registers per READ cycle and streams them out.
// Define REGDUMP_CHKSUM_EN to append a wrapping checksum word after register 7.
module regfile_dump
   import regfile_pkg::*;
#(
   parameter int DATA_W   = REG_DATA_W,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int NUM_REGS = REG_NUM
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd_addr1,
   output logic [ADDR_W-1:0] rd_addr2,
   input  logic [DATA_W-1:0] rd_data1,
   input  logic [DATA_W-1:0] rd_data2,
   regfile_dump_if.master    dump
);
   localparam int                PAIR_W = ADDR_W - 1;
   localparam logic [PAIR_W-1:0] LAST_P = PAIR_W'(NUM_REGS / 2 - 1);
`ifdef REGDUMP_CHKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   dump_state_e       state_q, state_d;
   logic [PAIR_W-1:0] p_q, p_d;
   logic [DATA_W-1:0] word;
   logic              sending;

   assign sending = (state_q == S_SEND0) || (state_q == S_SEND1);

   regdump_pair_buf #(.DATA_W(DATA_W)) u_pair_buf (
      .clock (clock),
      .load  (state_q == S_READ),
      .d0    (rd_data1),
      .d1    (rd_data2),
      .sel   (state_q == S_SEND1),
      .oe    (sending),
      .q     (word)
   );

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
      end
   end

`ifdef REGDUMP_CHKSUM_EN
   logic [DATA_W-1:0] sum_q;

   // Only register words are summed; the carry out of DATA_W is dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         sum_q <= '0;
      end else if (state_q == S_IDLE && start) begin
         sum_q <= '0;
      end else if (sending && dump.out_ready) begin
         sum_q <= sum_q + word;
      end
   end
`endif

   // NOTE: every signal written here gets a default first so no path infers a latch.
   always_comb begin
      state_d        = state_q;
      p_d            = p_q;
      busy           = (state_q != S_IDLE) && (state_q != S_DONE);
      done           = 1'b0;
      rd_addr1       = ADDR_W'(0);
      rd_addr2       = ADDR_W'(1);
      dump.out_valid = 1'b0;
      dump.out_index = '0;
      dump.out_last  = 1'b0;
      dump.out_chk   = 1'b0;
      dump.out_data  = word;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_READ;
               p_d     = '0;
            end
         end
         S_READ: begin
            rd_addr1 = {p_q, 1'b0};
            rd_addr2 = {p_q, 1'b1};
            state_d  = S_SEND0;
         end
         S_SEND0: begin
            dump.out_valid = 1'b1;
            dump.out_index = {p_q, 1'b0};
            if (dump.out_ready) state_d = S_SEND1;
         end
         S_SEND1: begin
            dump.out_valid = 1'b1;
            dump.out_index = {p_q, 1'b1};
            dump.out_last  = (p_q == LAST_P) && !CHK_EN;
            if (dump.out_ready) begin
               if (p_q == LAST_P) begin
`ifdef REGDUMP_CHKSUM_EN
                  state_d = S_CHK;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  p_d     = p_q + 1'b1;
                  state_d = S_READ;
               end
            end
         end
`ifdef REGDUMP_CHKSUM_EN
         S_CHK: begin
            dump.out_valid = 1'b1;
            dump.out_data  = sum_q;
            dump.out_last  = 1'b1;
            dump.out_chk   = 1'b1;
            if (dump.out_ready) state_d = S_DONE;
         end
`endif
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a per-cycle vector table for the nominal dump, and a word
// scoreboard for stall, restart, reset and wrap cases. Define REGDUMP_CHKSUM_EN for both.
`timescale 1ns/1ps
module tb_regfile_dump;
   import regfile_pkg::*;

`ifdef REGDUMP_CHKSUM_EN
   localparam bit CHK_ON = 1'b1;
`else
   localparam bit CHK_ON = 1'b0;
`endif

   logic      clock = 1'b0;
   logic      reset;
   logic      start;
   logic      busy, done;
   reg_addr_t rd_addr1, rd_addr2;
   reg_data_t rd_data1, rd_data2;
   reg_data_t rf [8];

   regfile_dump_if dump_if ();

   regfile_dump dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .rd_addr1 (rd_addr1),
      .rd_addr2 (rd_addr2),
      .rd_data1 (rd_data1),
      .rd_data2 (rd_data2),
      .dump     (dump_if)
   );

   always #5 clock = ~clock;

   // Combinational register-file read ports.
   assign rd_data1 = rf[rd_addr1];
   assign rd_data2 = rf[rd_addr2];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic       valid;
      logic [2:0] index;
      logic [15:0] data;
      logic       last;
      logic       chk;
      logic       busy;
      logic       done;
      logic [2:0] a1;
      logic [2:0] a2;
   } obs_t;

   typedef struct {
      logic start;
      obs_t exp;
   } vec_t;

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  index;
      logic        last;
      logic        chk;
   } word_t;

   function automatic obs_t mk(input int v, input int idx, input int d, input int l,
                               input int ck, input int b, input int dn, input int a1,
                               input int a2);
      obs_t o;
      o.valid = v[0];
      o.index = idx[2:0];
      o.data  = d[15:0];
      o.last  = l[0];
      o.chk   = ck[0];
      o.busy  = b[0];
      o.done  = dn[0];
      o.a1    = a1[2:0];
      o.a2    = a2[2:0];
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.valid = dump_if.out_valid;
      o.index = dump_if.out_index;
      o.data  = dump_if.out_data;
      o.last  = dump_if.out_last;
      o.chk   = dump_if.out_chk;
      o.busy  = busy;
      o.done  = done;
      o.a1    = rd_addr1;
      o.a2    = rd_addr2;
      return o;
   endfunction

   // Scoreboard: expected words queued when a start is driven, popped on each handshake.
   word_t       sb_q[$];
   logic        stall_prev = 1'b0;
   word_t       held;
   logic [15:0] last_chk = '0;

   task automatic push_dump();
      logic [15:0] sum;
      word_t w;
      sum = '0;
      for (int i = 0; i < 8; i++) begin
         w.data  = rf[i];
         w.index = 3'(i);
         w.last  = (i == 7) && !CHK_ON;
         w.chk   = 1'b0;
         sb_q.push_back(w);
         sum = sum + rf[i];
      end
      if (CHK_ON) begin
         w.data  = sum;
         w.index = 3'd0;
         w.last  = 1'b1;
         w.chk   = 1'b1;
         sb_q.push_back(w);
      end
   endtask

   always @(negedge clock) begin : monitor
      word_t cur, exp_w;
      cur = {dump_if.out_data, dump_if.out_index, dump_if.out_last, dump_if.out_chk};
      if (reset) begin
         sb_q.delete();
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev) check("stalled word held", {1'b1, cur}, {dump_if.out_valid, held});
         if (dump_if.out_valid && dump_if.out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra word: got %h, required no word", cur);
            end else begin
               exp_w = sb_q.pop_front();
               check($sformatf("word idx %0d chk %0d", exp_w.index, exp_w.chk), cur, exp_w);
               if (cur.chk) last_chk <= cur.data;
            end
         end
         stall_prev <= dump_if.out_valid && !dump_if.out_ready;
         held       <= cur;
      end
   end

   task automatic load_ramp(input int step);
      for (int i = 0; i < 8; i++) rf[i] = 16'(step * (i + 1));
   endtask

   // Starts at cycle 0 (called right after a rising edge); optional stall window and
   // a second start pulse mid-dump. Checks the done cycle, a single done and a drained
   // scoreboard.
   task automatic do_dump(input string tag, input int stall_at, input int stall_len,
                          input int restart_at, input int exp_done);
      int done_cyc;
      int dn;
      done_cyc = -1;
      dn       = 0;
      push_dump();
      start = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clock);
         if (done) begin
            dn++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (done_cyc >= 0 && c >= done_cyc + 4) break;
         @(posedge clock);
         #1;
         start = (c + 1 == restart_at);
         dump_if.out_ready = !((c + 1) >= stall_at && (c + 1) < stall_at + stall_len);
      end
      start = 1'b0;
      dump_if.out_ready = 1'b1;
      check({tag, " done cycle"}, 64'(done_cyc), 64'(exp_done));
      check({tag, " done count"}, 64'(dn), 64'd1);
      check({tag, " scoreboard drained"}, 64'(sb_q.size()), 64'd0);
      @(posedge clock);
      #1;
   endtask

   vec_t vec [16];
   int   nvec;
   obs_t idle_obs;

   initial begin
      idle_obs = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Nominal dump, out_ready high: READ every third cycle, words on the other two.
      vec[0] = '{1'b1, idle_obs};
      for (int k = 0; k < 4; k++) begin
         vec[1 + 3*k] = '{1'b0, mk(0, 0, 0, 0, 0, 1, 0, 2*k, 2*k + 1)};
         vec[2 + 3*k] = '{1'b0, mk(1, 2*k, 10*(2*k + 1), 0, 0, 1, 0, 0, 1)};
         vec[3 + 3*k] = '{1'b0, mk(1, 2*k + 1, 10*(2*k + 2), (k == 3) && !CHK_ON, 0, 1, 0, 0, 1)};
      end
      if (CHK_ON) begin
         vec[13] = '{1'b0, mk(1, 0, 16'h0168, 1, 1, 1, 0, 0, 1)};
         vec[14] = '{1'b0, mk(0, 0, 0, 0, 0, 0, 1, 0, 1)};
         vec[15] = '{1'b0, idle_obs};
         nvec    = 16;
      end else begin
         vec[13] = '{1'b0, mk(0, 0, 0, 0, 0, 0, 1, 0, 1)};
         vec[14] = '{1'b0, idle_obs};
         nvec    = 15;
      end

      reset = 1'b1;
      start = 1'b0;
      dump_if.out_ready = 1'b1;
      load_ramp(10);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("reset state", sample(), idle_obs);
      @(posedge clock);
      #1;

      push_dump();
      for (int c = 0; c < nvec; c++) begin
         start = vec[c].start;
         @(negedge clock);
         check($sformatf("table cycle %0d", c), sample(), vec[c].exp);
         @(posedge clock);
         #1;
      end
      check("table scoreboard drained", 64'(sb_q.size()), 64'd0);
`ifdef REGDUMP_CHKSUM_EN
      check("checksum 10..80", 64'(last_chk), 64'h0168);
`endif

      // Consumer stalls for 3 cycles while R3 is presented.
      do_dump("stall", 6, 3, -1, 16 + int'(CHK_ON));

      // Second start pulse mid-dump is ignored.
      do_dump("restart", 99, 0, 5, 13 + int'(CHK_ON));

      // Reset during cycle 6 aborts the dump without a done pulse.
      begin
         int dn;
         dn = 0;
         push_dump();
         start = 1'b1;
         for (int c = 0; c < 6; c++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
         end
         reset = 1'b1;
         @(posedge clock);
         #1;
         reset = 1'b0;
         @(negedge clock);
         check("mid-dump reset state", sample(), idle_obs);
         for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (done) dn++;
         end
         check("no done after reset", 64'(dn), 64'd0);
         @(posedge clock);
         #1;
      end
      do_dump("after reset", 99, 0, -1, 13 + int'(CHK_ON));

      // All-ones registers: the checksum wraps.
      for (int i = 0; i < 8; i++) rf[i] = 16'hFFFF;
      do_dump("all ones", 99, 0, -1, 13 + int'(CHK_ON));
`ifdef REGDUMP_CHKSUM_EN
      check("checksum wrap", 64'(last_chk), 64'hFFF8);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug/readback engine for the 8 x 16-bit register file. On a `start` pulse it drives the register file's two combinational read ports, walking addresses 0..7 in pairs, and captures each pair in one cycle. It then streams every register value out on a valid/ready word interface. It sits beside the MIPS datapath on the read-port side of the register file and feeds a trace/UART/debug consumer.

## Interface
Parameters:
- `DATA_W`, 16, register width
- `ADDR_W`, 3, register address width
- `NUM_REGS`, 8, registers dumped; must be even and equal 2**ADDR_W

Ports:
- `clock`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE
- `busy`  out  1  high from the first cycle after an accepted start until done
- `done`  out  1  one-cycle pulse after the final word handshake
- `rd_addr1`  out  ADDR_W  to register file read port 1 (`RReg1`)
- `rd_addr2`  out  ADDR_W  to register file read port 2 (`RReg2`)
- `rd_data1`  in  DATA_W  from `RRead1`, combinational in `rd_addr1`
- `rd_data2`  in  DATA_W  from `RRead2`, combinational in `rd_addr2`
- `out_valid`  out  1  `out_data` holds a word
- `out_ready`  in  1  consumer accepts; transfer when valid & ready
- `out_data`  out  DATA_W  register value (or checksum)
- `out_index`  out  ADDR_W  register number of `out_data`
- `out_last`  out  1  final word of this dump
- `out_chk`  out  1  word is the checksum (always 0 when the feature is off)

## Operation
- FSM states: IDLE, READ, SEND0, SEND1, CHK, DONE. Pair counter `p` (0..NUM_REGS/2-1).
- IDLE: `start` = 1 -> READ with p = 0.
- READ (1 cycle): `rd_addr1` = 2p, `rd_addr2` = 2p+1. Capture both `rd_data` values into a 2-entry pair buffer at cycle end -> SEND0. The pair is therefore coherent.
- SEND0: present buffer[0] with index 2p. On handshake -> SEND1.
- SEND1: present buffer[1] with index 2p+1. On handshake:
  - p < last: p++, -> READ.
  - otherwise: -> CHK if the checksum is enabled, else -> DONE.
- CHK: present the running sum. On handshake -> DONE.
- DONE (1 cycle): `done` = 1, `busy` = 0 -> IDLE.
- `out_last` is 1 on the final word only: index 7 with the checksum off, the CHK word with it on.
- `start` outside IDLE is ignored. It is not queued.
- Register writes during a dump are not tracked. Values are the ones sampled in that pair's READ cycle.
- `rd_addr1`/`rd_addr2` hold 0/1 outside READ.

## Timing
- Reset values: state IDLE, p = 0; `busy`, `done`, `out_valid`, `out_last`, `out_chk` = 0; `out_data` = 0, `out_index` = 0; `rd_addr1` = 0, `rd_addr2` = 1; checksum = 0.
- `reset` mid-dump aborts at the next edge: all of the above are restored, no `done` pulse, partial stream abandoned.
- With `start` at cycle 0 and `out_ready` held high:
  - READ at cycle 1; R0 at cycle 2; R1 at cycle 3; READ at cycle 4.
  - R7 at cycle 12; `done` at cycle 13 (checksum off).
  - With the checksum on: CHK at cycle 13, `done` at cycle 14.
- Each pair costs 3 cycles plus stall cycles.
- While `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_index`, `out_last` and `out_chk` hold stable. `out_valid` never drops without a handshake, except on reset.
- `out_valid` is 0 in IDLE, READ and DONE.

## Configuration
- `REGDUMP_CHKSUM_EN` defined:
  - Adds the CHK state and a DATA_W accumulator. It clears on an accepted start and adds each word at its handshake, modulo 2**DATA_W (carry discarded).
  - The checksum is emitted as a ninth word with `out_chk` = 1, `out_index` = 0 and `out_last` = 1.
- Undefined: no accumulator and no CHK state; `out_chk` is tied to 0.

## Structure
- Shared package/include `regfile_pkg`: DATA_W, ADDR_W and NUM_REGS constants, the FSM state encoding, and the register-file port widths shared with `Regfile`.
- One natural sub-module, `regdump_pair_buf`:
  - 2 x DATA_W capture register with load and select.
  - Output mux for `out_data`.
- FSM, counter and checksum stay in the top.

## Test plan
- Regfile loaded R0..R7 = 10,20,...,80; start; `out_ready` = 1 -> words 10..80 with indices 0..7 at cycles 2,3,5,6,8,9,11,12; `out_last` on 80; `done` at cycle 13.
- Same load; `out_ready` low 3 cycles while R3 (40) is presented -> data/index held stable; stream order unchanged; `done` delayed by 3 cycles.
- `start` pulsed again at cycle 5 mid-dump -> ignored; exactly 8 words and one `done`.
- `reset` at cycle 6 -> next cycle all outputs at reset values, no `done`; a new start gives a full 10..80 dump.
- `REGDUMP_CHKSUM_EN`, values 10..80 -> ninth word 0x0168 (360) with `out_chk` = 1 and `out_last` = 1; all registers 0xFFFF -> checksum 0xFFF8 (wrap).
